// File: rtl/capture_readout_if.sv
// Capture readout bus: sample-RAM read port plus the valid/ready sample stream toward the host link.
interface capture_readout_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] i_mem_data;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  i_ready;

  modport master (
    output o_mem_addr,
    input  i_mem_data,
    output o_data,
    output o_valid,
    input  i_ready
  );

  modport slave (
    input  o_mem_addr,
    output i_mem_data,
    input  o_data,
    input  o_valid,
    output i_ready
  );
endinterface

// File: rtl/capture_readout.sv
// Walks the circular capture RAM from the oldest sample and streams every word out once per stop event.
// Optional macro READOUT_HEADER_EN inserts a 'hA5 header word ahead of the samples.
module capture_readout #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stopped,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  capture_readout_if.master     bus,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_FETCH  = 3'd2,
    ST_LOAD   = 3'd3,
    ST_SEND   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [DATA_WIDTH-1:0] HEADER_WORD = DATA_WIDTH'(8'hA5);
  localparam logic [ADDR_WIDTH-1:0] LAST_COUNT  = {ADDR_WIDTH{1'b1}};

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH-1:0] count_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  valid_r;
  logic                  busy_r;
  logic                  done_r;

  assign bus.o_mem_addr = mem_addr_r;
  assign bus.o_data     = data_r;
  assign bus.o_valid    = valid_r;
  assign o_busy         = busy_r;
  assign o_done         = done_r;

  // Readout sequencer; dropping stopped mid-transfer aborts and wins over a same-cycle handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
      count_r    <= {ADDR_WIDTH{1'b0}};
      mem_addr_r <= {ADDR_WIDTH{1'b0}};
      data_r     <= {DATA_WIDTH{1'b0}};
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (stopped) begin
            rd_ptr_r   <= i_wr_addr;
            mem_addr_r <= i_wr_addr;
            count_r    <= {ADDR_WIDTH{1'b0}};
            busy_r     <= 1'b1;
`ifdef READOUT_HEADER_EN
            state_r    <= ST_HEADER;
`else
            state_r    <= ST_FETCH;
`endif
          end
        end
        ST_HEADER: begin
          if (!stopped) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end else if (!valid_r) begin
            data_r  <= HEADER_WORD;
            valid_r <= 1'b1;
          end else if (bus.i_ready) begin
            valid_r <= 1'b0;
            state_r <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!stopped) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!stopped) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            data_r  <= bus.i_mem_data;
            valid_r <= 1'b1;
            state_r <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!stopped) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end else if (valid_r && bus.i_ready) begin
            valid_r <= 1'b0;
            if (count_r == LAST_COUNT) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              // Pointer wraps silently through the circular buffer.
              count_r    <= count_r + ADDR_WIDTH'(1);
              rd_ptr_r   <= rd_ptr_r + ADDR_WIDTH'(1);
              mem_addr_r <= rd_ptr_r + ADDR_WIDTH'(1);
              state_r    <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          if (!stopped) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_readout.sv
// Self-checking bench for capture_readout (ADDR_WIDTH=3): directed test-plan cases plus randomized readouts
// checked against an arithmetic model of the expected circular word order.
module tb_capture_readout;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int DEPTH = 8;
`ifdef READOUT_HEADER_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stopped = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic          busy;
  logic          done;

  capture_readout_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  capture_readout #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .stopped   (stopped),
    .i_wr_addr (wr_addr),
    .bus       (bus),
    .o_busy    (busy),
    .o_done    (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) bus.i_mem_data <= ram[bus.o_mem_addr];

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] got[$];
  logic [DW-1:0] exp_q[$];
  int lat;
  int unstable;
  bit finished;
  bit scramble = 1'b0;

  // Expected word order: optional header, then RAM from the oldest sample around the ring.
  task automatic build_exp(input int wr);
    exp_q.delete();
`ifdef READOUT_HEADER_EN
    exp_q.push_back(8'hA5);
`endif
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(ram[(wr + i) % DEPTH]);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 16);
  endtask

  // Raises stopped and drives i_ready per mode until done; records accepted words, latency and stalls that moved.
  task automatic collect(input int wr, input int mode);
    logic [DW-1:0] pd;
    logic pv, pr;
    int vcyc;
    got.delete();
    lat = -1; unstable = 0; finished = 1'b0; pv = 1'b0; pr = 1'b0; pd = '0; vcyc = 0;
    wr_addr = wr[AW-1:0];
    stopped = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (scramble) wr_addr = AW'($urandom);
      case (mode)
        0: bus.i_ready = 1'b1;
        1: bus.i_ready = (cyc % 3 == 0);
        2: bus.i_ready = 1'($urandom_range(0, 1));
        3: bus.i_ready = (vcyc >= 4);
        default: bus.i_ready = 1'b1;
      endcase
      if (pv && !pr && (!bus.o_valid || bus.o_data !== pd)) unstable++;
      if (bus.o_valid && lat < 0) lat = cyc;
      if (bus.o_valid) vcyc++;
      if (bus.o_valid && bus.i_ready) got.push_back(bus.o_data);
      pv = bus.o_valid; pr = bus.i_ready; pd = bus.o_data;
      if (done) begin
        finished = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_stop();
    stopped = 1'b0;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release: done=%b busy=%b, required 0/0", done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stopped = 1'b0; bus.i_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.o_mem_addr !== 3'd0 || bus.o_data !== 8'd0 || bus.o_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%0d data=%h valid=%b busy=%b done=%b, required all 0",
               bus.o_mem_addr, bus.o_data, bus.o_valid, busy, done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Full readout with fixed ready pattern; checks order, latency, stall stability, done and last address.
  task automatic test_readout(input string name, input int wr, input int mode);
    fill_ramp();
    build_exp(wr);
    collect(wr, mode);
    n_tests++;
    if (!finished) begin
      n_fail++;
      $display("FAIL %s_timeout: done never rose, required done=1", name);
    end
    n_tests++;
    if (lat !== EXP_LAT) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, EXP_LAT);
    end
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d words, required %0d", name, got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (got[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s_word%0d: got %h, required %h", name, i, got[i], exp_q[i]);
        end
      end
    end
    n_tests++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL %s_stall: %0d stalled cycles changed data/valid, required 0", name, unstable);
    end
    n_tests++;
    if (busy !== 1'b0 || bus.o_mem_addr !== AW'((wr + DEPTH - 1) % DEPTH)) begin
      n_fail++;
      $display("FAIL %s_end: busy=%b addr=%0d, required busy=0 addr=%0d", name, busy, bus.o_mem_addr,
               (wr + DEPTH - 1) % DEPTH);
    end
    release_stop();
  endtask

  task automatic test_abort();
    int cyc;
    fill_ramp();
    build_exp(5);
    got.delete();
    wr_addr = 3'd5;
    stopped = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.i_ready = 1'b1;
      if (bus.o_valid && got.size() == 3) begin
        stopped = 1'b0;
        break;
      end
      if (bus.o_valid) got.push_back(bus.o_data);
    end
    @(negedge clk);
    n_tests++;
    if (bus.o_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: valid=%b busy=%b done=%b, required 0/0/0", bus.o_valid, busy, done);
    end
    n_tests++;
    if (got.size() != 3 || got[0] !== exp_q[0] || got[1] !== exp_q[1] || got[2] !== exp_q[2]) begin
      n_fail++;
      $display("FAIL abort_words: got %0d words, required 3 matching the model", got.size());
    end
    repeat (2) @(negedge clk);
    test_readout("abort_restart", 5, 0);
  endtask

  task automatic test_reset_midop();
    fill_ramp();
    test_readout("pre_reset", 5, 0);
    wr_addr = 3'd5;
    stopped = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stopped = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.o_mem_addr !== 3'd0 || bus.o_data !== 8'd0 || bus.o_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midop: addr=%0d data=%h valid=%b busy=%b done=%b, required all 0",
               bus.o_mem_addr, bus.o_data, bus.o_valid, busy, done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_done_hold();
    fill_ramp();
    collect(2, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.o_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
        n_fail++;
        $display("FAIL done_hold: cycle %0d valid=%b busy=%b done=%b, required 0/0/1", i, bus.o_valid, busy, done);
      end
    end
    release_stop();
    test_readout("after_hold", 2, 0);
  endtask

  // Random RAM contents, start pointer and ready; wr_addr is scrambled after start and must be ignored.
  task automatic test_random();
    int wr;
    scramble = 1'b1;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
      wr = $urandom_range(0, DEPTH - 1);
      build_exp(wr);
      collect(wr, 2);
      n_tests++;
      if (!finished || got.size() != exp_q.size() || unstable != 0) begin
        n_fail++;
        $display("FAIL random%0d: finished=%b words=%0d unstable=%0d, required 1/%0d/0",
                 it, finished, got.size(), unstable, exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_tests++;
          if (got[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL random%0d_word%0d: got %h, required %h", it, i, got[i], exp_q[i]);
          end
        end
      end
      stopped = 1'b0;
      @(negedge clk);
    end
    scramble = 1'b0;
  endtask

  initial begin
    bus.i_ready = 1'b0;
    fill_ramp();
    test_reset();
    test_readout("basic", 5, 0);
    test_readout("toggle", 5, 1);
    test_readout("wrap0", 0, 0);
    test_readout("wrap7", 7, 0);
    test_abort();
    test_reset_midop();
    test_done_hold();
`ifdef READOUT_HEADER_EN
    test_readout("header_stall", 5, 3);
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
